// File: rtl/grid_pkg.sv
// Shared grid geometry, raster timing and colour constants for the grid driver and scanout.
package grid_pkg;
  localparam int GRID_ROWS  = 30;
  localparam int GRID_COLS  = 40;
  localparam int CELL_PX    = 8;
  localparam int GRID_CELLS = GRID_ROWS * GRID_COLS;
  localparam int H_ACTIVE   = GRID_COLS * CELL_PX;
  localparam int H_TOTAL    = 400;
  localparam int H_SYNC_POS = 360;
  localparam int V_ACTIVE   = GRID_ROWS * CELL_PX;
  localparam int V_TOTAL    = 262;
  localparam logic [23:0] ON_COLOR   = 24'hFFFFFF;
  localparam logic [23:0] OFF_COLOR  = 24'h000000;
  localparam logic [23:0] LINE_COLOR = 24'h404040;
endpackage

// File: rtl/grid_scanout_video_timing_gen.sv
// Raster counters plus first-stage registered de/hs/vs and the once-per-frame snapshot strobe.
module video_timing_gen #(
  parameter int H_ACTIVE   = grid_pkg::H_ACTIVE,
  parameter int H_TOTAL    = grid_pkg::H_TOTAL,
  parameter int H_SYNC_POS = grid_pkg::H_SYNC_POS,
  parameter int V_ACTIVE   = grid_pkg::V_ACTIVE,
  parameter int V_TOTAL    = grid_pkg::V_TOTAL,
  localparam int HW = $clog2(H_TOTAL),
  localparam int VW = $clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [HW-1:0] o_h_cnt,
  output logic [VW-1:0] o_v_cnt,
  output logic          o_snap,
  output logic          o_de_p1,
  output logic          o_hs_p1,
  output logic          o_vs_p1,
  output logic          o_frame_tick
);
  import grid_pkg::*;

  logic [HW-1:0] r_h;
  logic [VW-1:0] r_v;
  logic          w_h_last;
  logic          w_v_last;

  assign w_h_last = (r_h == HW'(H_TOTAL - 1));
  assign w_v_last = (r_v == VW'(V_TOTAL - 1));
  assign o_snap   = w_h_last && w_v_last;
  assign o_h_cnt  = r_h;
  assign o_v_cnt  = r_v;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h          <= '0;
      r_v          <= '0;
      o_de_p1      <= 1'b0;
      o_hs_p1      <= 1'b0;
      o_vs_p1      <= 1'b0;
      o_frame_tick <= 1'b0;
    end else begin
      r_h <= w_h_last ? '0 : r_h + 1'b1;
      if (w_h_last) r_v <= w_v_last ? '0 : r_v + 1'b1;
      // S1: raw sync/enable for the counter value of this cycle
      o_de_p1      <= (r_h < HW'(H_ACTIVE)) && (r_v < VW'(V_ACTIVE));
      o_hs_p1      <= (r_h == HW'(H_SYNC_POS));
      o_vs_p1      <= (r_h == '0) && (r_v == VW'(V_ACTIVE));
      o_frame_tick <= o_snap;
    end
  end
endmodule

// File: rtl/grid_scanout.sv
// Grid-to-raster scanout: per-frame snapshot of grid_ram, 2-cycle index/colour pipeline.
// Optional cell outline overlay when GRID_SCANOUT_LINES_EN is defined. reset_n must be released synchronously to clk.
module grid_scanout #(
  parameter int GRID_ROWS  = grid_pkg::GRID_ROWS,
  parameter int GRID_COLS  = grid_pkg::GRID_COLS,
  parameter int CELL_PX    = grid_pkg::CELL_PX,
  parameter int H_TOTAL    = grid_pkg::H_TOTAL,
  parameter int H_SYNC_POS = grid_pkg::H_SYNC_POS,
  parameter int V_TOTAL    = grid_pkg::V_TOTAL,
  parameter logic [23:0] ON_COLOR  = grid_pkg::ON_COLOR,
  parameter logic [23:0] OFF_COLOR = grid_pkg::OFF_COLOR
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [GRID_ROWS*GRID_COLS-1:0] grid_ram,
  output logic                           frame_tick,
  output logic [23:0]                    vid_rgb,
  output logic                           vid_hs,
  output logic                           vid_vs,
  output logic                           vid_de
);
  import grid_pkg::*;

  localparam int N_CELLS = GRID_ROWS * GRID_COLS;
  localparam int H_ACT   = GRID_COLS * CELL_PX;
  localparam int V_ACT   = GRID_ROWS * CELL_PX;
  localparam int IDX_W   = $clog2(N_CELLS);
  localparam int SH      = $clog2(CELL_PX);
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  logic [HW-1:0]      w_h;
  logic [VW-1:0]      w_v;
  logic               w_snap;
  logic               w_de_p1;
  logic               w_hs_p1;
  logic               w_vs_p1;
  logic [31:0]        w_cell;
  logic [IDX_W-1:0]   r_idx_p1;
  logic [N_CELLS-1:0] r_frame_buf;
`ifdef GRID_SCANOUT_LINES_EN
  logic               r_line_p1;
`endif

  video_timing_gen #(
    .H_ACTIVE  (H_ACT),
    .H_TOTAL   (H_TOTAL),
    .H_SYNC_POS(H_SYNC_POS),
    .V_ACTIVE  (V_ACT),
    .V_TOTAL   (V_TOTAL)
  ) u_timing (
    .clk         (clk),
    .rst_n       (reset_n),
    .o_h_cnt     (w_h),
    .o_v_cnt     (w_v),
    .o_snap      (w_snap),
    .o_de_p1     (w_de_p1),
    .o_hs_p1     (w_hs_p1),
    .o_vs_p1     (w_vs_p1),
    .o_frame_tick(frame_tick)
  );

  assign w_cell = 32'(w_v >> SH) * 32'(GRID_COLS) + 32'(w_h >> SH);

  // S1: cell index, clamped so blanking positions never address past the grid
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_idx_p1  <= '0;
`ifdef GRID_SCANOUT_LINES_EN
      r_line_p1 <= 1'b0;
`endif
    end else begin
      r_idx_p1  <= (w_cell < 32'(N_CELLS)) ? IDX_W'(w_cell) : '0;
`ifdef GRID_SCANOUT_LINES_EN
      r_line_p1 <= (w_h[SH-1:0] == '0) || (w_v[SH-1:0] == '0);
`endif
    end
  end

  // S2: snapshot buffer and registered video outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_frame_buf <= '0;
      vid_rgb     <= '0;
      vid_de      <= 1'b0;
      vid_hs      <= 1'b0;
      vid_vs      <= 1'b0;
    end else begin
      if (w_snap) r_frame_buf <= grid_ram;
      vid_de <= w_de_p1;
      vid_hs <= w_hs_p1;
      vid_vs <= w_vs_p1;
      if (!w_de_p1)
        vid_rgb <= '0;
`ifdef GRID_SCANOUT_LINES_EN
      else if (r_line_p1)
        vid_rgb <= LINE_COLOR;
`endif
      else
        vid_rgb <= r_frame_buf[r_idx_p1] ? ON_COLOR : OFF_COLOR;
    end
  end
endmodule
